div_clk_checker: RTL and testbench

Cycle-accurate checker that sits directly downstream of the odd clock divider. It samples the divided clock in the source clock domain and measures each divided period and its high time in source-clock cycles. It declares lock after a run of correct periods and flags wrong-ratio, bad-duty and stopped-clock faults. It serves as a bring-up self-check and as a functional monitor in simulation and silicon.

---
 rtl/div_clk_pkg.sv | 22 ++
 rtl/div_clk_checker_edge_sampler.sv | 27 ++
 rtl/div_clk_checker.sv | 146 ++++++++++++++
 tb/tb_div_clk_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_pkg.sv
// Shared types and helpers for the divided-clock checker.
package div_clk_pkg;

  typedef enum logic [0:0] {IDLE, MEASURE} state_e;

  localparam int unsigned DefCntW = 8;

  // True when twice the high time is within one cycle of the period.
  // Both values are zero-extended, so the difference cannot wrap for any
  // counter width up to 32 bits.
  function automatic logic duty_ok(input logic [31:0] period, input logic [31:0] high);
    logic [33:0] two_h;
    logic [33:0] p;
    two_h = {1'b0, high, 1'b0};
    p     = {2'b00, period};
    if (two_h >= p) begin
      return (two_h - p) <= 34'd1;
    end
    return (p - two_h) <= 34'd1;
  endfunction

endpackage

// File: rtl/div_clk_checker_edge_sampler.sv
// Two-flop sampler of the divided clock with rising-edge detect.
module edge_sampler (
  input  logic clk_in,
  input  logic reset,
  input  logic sig,
  output logic s1,
  output logic rise
);

  logic s1_q;
  logic s2_q;

  // Sample the incoming divided clock as plain data.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sig;
      s2_q <= s1_q;
    end
  end

  assign s1   = s1_q;
  assign rise = s1_q & ~s2_q;

endmodule

// File: rtl/div_clk_checker.sv
// Measures period and high time of a divided clock, tracks lock and faults.
module div_clk_checker
  import div_clk_pkg::*;
#(
  parameter int unsigned EXP_DIV    = 3,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam int unsigned MatchW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [CNT_W-1:0]  ExpDiv   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  logic s1;
  logic rise;

  edge_sampler u_sampler (
    .clk_in (clk_in),
    .reset  (reset),
    .sig    (div_clk),
    .s1     (s1),
    .rise   (rise)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              stuck_q, stuck_d;

  logic              good;
  logic [MatchW-1:0] match_inc;

  // Next-state logic: counting, measurement reporting, lock and timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    match_d   = match_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    err_d     = 1'b0;
    stuck_d   = stuck_q;

    good      = (cnt_q == ExpDiv) && duty_ok(32'(cnt_q), 32'(hcnt_q));
    match_inc = (match_q == MatchMax) ? match_q : match_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CntOne;
          hcnt_d  = CntOne;
          stuck_d = 1'b0;
        end
      end
      MEASURE: begin
        // A rise on the terminal count still completes the measurement.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = CntOne;
          hcnt_d   = CntOne;
          if (good) begin
            match_d = match_inc;
            if (match_inc == MatchMax) begin
              locked_d = 1'b1;
            end
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end else if (cnt_q == CntMax) begin
          state_d  = IDLE;
          cnt_d    = '0;
          hcnt_d   = '0;
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronously cleared.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker with a scoreboard of expected measurements.
module tb_div_clk_checker;

  typedef struct {
    int p;
    int hmin;
    int hmax;
    bit err;
    bit lock;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic div3   = 1'b0;
  logic div5   = 1'b0;

  logic [7:0] period3, high3, period5, high5;
  logic       mv3, lk3, er3, st3, mv5, lk5, er5, st5;

  int checks = 0;
  int errors = 0;

  exp_t sb3[$];
  exp_t sb5[$];
  int   match_m[2];
  bit   have_prev[2];
  int   prev_p[2];
  int   prev_hmin[2];
  int   prev_hmax[2];
  int   exp_div[2] = '{3, 5};

  always #5 clk_in = ~clk_in;

  div_clk_checker #(.EXP_DIV(3), .CNT_W(8), .LOCK_COUNT(4)) u_dut3 (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_clk    (div3),
    .period     (period3),
    .high_time  (high3),
    .meas_valid (mv3),
    .locked     (lk3),
    .err        (er3),
    .stuck      (st3)
  );

  div_clk_checker #(.EXP_DIV(5), .CNT_W(8), .LOCK_COUNT(4)) u_dut5 (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_clk    (div5),
    .period     (period5),
    .high_time  (high5),
    .meas_valid (mv5),
    .locked     (lk5),
    .err        (er5),
    .stuck      (st5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit duty_good(input int p, input int h);
    int d;
    d = 2 * h - p;
    return (d >= -1) && (d <= 1);
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_div(input int id, input logic v);
    if (id == 0) div3 = v;
    else div5 = v;
  endtask

  // Called as each new period starts: the previous period becomes reportable.
  task automatic note_rise(input int id, input int p, input int hmin, input int hmax);
    exp_t e;
    bit   good;
    if (have_prev[id]) begin
      good = (prev_p[id] == exp_div[id]) && duty_good(prev_p[id], prev_hmin[id])
             && duty_good(prev_p[id], prev_hmax[id]);
      if (good) match_m[id] = (match_m[id] < 4) ? match_m[id] + 1 : 4;
      else match_m[id] = 0;
      e.p    = prev_p[id];
      e.hmin = prev_hmin[id];
      e.hmax = prev_hmax[id];
      e.err  = !good;
      e.lock = (match_m[id] == 4);
      if (id == 0) sb3.push_back(e);
      else sb5.push_back(e);
    end
    have_prev[id] = 1'b1;
    prev_p[id]    = p;
    prev_hmin[id] = hmin;
    prev_hmax[id] = hmax;
  endtask

  task automatic clear_model(input int id);
    have_prev[id] = 1'b0;
    match_m[id]   = 0;
  endtask

  // Integer-cycle period: high for hi samples, low for lo samples.
  task automatic drive_int(input int id, input int hi, input int lo);
    note_rise(id, hi + lo, hi, hi);
    set_div(id, 1'b1);
    repeat (hi) cyc();
    set_div(id, 1'b0);
    repeat (lo) cyc();
  endtask

  // Divide-by-3 at 50% duty: falls on a negative edge, 1.5 cycles after rising.
  task automatic drive_ideal();
    note_rise(0, 3, 1, 2);
    div3 = 1'b1;
    cyc();
    @(negedge clk_in);
    #1;
    div3 = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic mon(input int id, input logic mv, input logic er, input logic lk,
                     input logic [7:0] p, input logic [7:0] h);
    exp_t e;
    bit   have;
    if (er && !mv) check($sformatf("dut%0d_err_with_valid", id), mv, 1);
    if (mv) begin
      have = (id == 0) ? (sb3.size() > 0) : (sb5.size() > 0);
      check($sformatf("dut%0d_meas_expected", id), have, 1);
      if (have) begin
        if (id == 0) e = sb3.pop_front();
        else e = sb5.pop_front();
        check($sformatf("dut%0d_period", id), p, e.p);
        check($sformatf("dut%0d_high_in_range_%0d_%0d_got_%0d", id, e.hmin, e.hmax, h),
              (h >= e.hmin) && (h <= e.hmax), 1);
        check($sformatf("dut%0d_err", id), er, e.err);
        check($sformatf("dut%0d_locked", id), lk, e.lock);
      end
    end
  endtask

  // Scoreboard side: pop an expectation whenever a measurement is reported.
  always @(negedge clk_in) begin
    mon(0, mv3, er3, lk3, period3, high3);
    mon(1, mv5, er5, lk5, period5, high5);
  end

  initial begin
    clear_model(0);
    clear_model(1);

    reset = 1'b1;
    repeat (3) cyc();
    check("rst_period3", period3, 0);
    check("rst_high3", high3, 0);
    check("rst_valid3", mv3, 0);
    check("rst_locked3", lk3, 0);
    check("rst_err3", er3, 0);
    check("rst_stuck3", st3, 0);
    check("rst_period5", period5, 0);
    check("rst_locked5", lk5, 0);
    check("rst_stuck5", st5, 0);
    reset = 1'b0;
    cyc();

    // Bad duty on the divide-by-5 checker, then a corrected 3/2 split.
    repeat (4) drive_int(1, 1, 4);
    repeat (6) drive_int(1, 3, 2);
    check("dut5_lock_after_fix", lk5, 1);

    // Ideal divide-by-3: lock at the 5th rise.
    repeat (5) drive_ideal();
    check("dut3_lock_ideal", lk3, 1);

    // Ratio change to 5 after lock: err and unlock together.
    repeat (3) drive_int(0, 3, 2);
    check("dut3_unlocked_div5", lk3, 0);

    // Back to divide-by-3 and relock.
    repeat (6) drive_ideal();
    check("dut3_relock", lk3, 1);

    // Stopped clock: last rise, then hold low.
    note_rise(0, 3, 1, 2);
    div3 = 1'b1;
    cyc();
    @(negedge clk_in);
    #1;
    div3 = 1'b0;
    cyc();
    repeat (254) cyc();
    check("stuck_before_timeout", st3, 0);
    check("locked_before_timeout", lk3, 1);
    cyc();
    check("stuck_at_timeout", st3, 1);
    check("locked_at_timeout", lk3, 0);
    clear_model(0);
    repeat (5) cyc();
    check("stuck_holds", st3, 1);
    check("period_holds", period3, 3);

    // Restart: stuck clears at the first rise, report at the second.
    note_rise(0, 3, 1, 2);
    div3 = 1'b1;
    cyc();
    check("stuck_before_rise", st3, 1);
    @(negedge clk_in);
    #1;
    div3 = 1'b0;
    cyc();
    check("stuck_cleared", st3, 0);
    cyc();
    repeat (5) drive_ideal();
    check("lock_after_restart", lk3, 1);

    // Reset mid-lock.
    reset = 1'b1;
    cyc();
    check("midrst_period", period3, 0);
    check("midrst_high", high3, 0);
    check("midrst_valid", mv3, 0);
    check("midrst_locked", lk3, 0);
    check("midrst_err", er3, 0);
    check("midrst_stuck", st3, 0);
    reset = 1'b0;
    clear_model(0);
    clear_model(1);
    repeat (4) drive_ideal();
    check("no_lock_after_4_rises", lk3, 0);
    drive_ideal();
    check("relock_after_reset", lk3, 1);

    repeat (4) cyc();
    check("sb3_drained", sb3.size(), 0);
    check("sb5_drained", sb5.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
